// File: rtl/bk_limb_sequencer.sv
// bk_limb_sequencer: streams operand limbs into an external W-bit carry-in adder,
// chains the carry between limbs and streams the sum limbs out, LS limb first.
// Latency: limb accepted at edge N -> result valid in cycle N+2; >= 3 cycles per limb.
// Backpressure: out_ready_i low holds EMIT with every result and adder register frozen.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start_i, len_i, cin_i    operation request (sampled in IDLE only)
//   a_i, b_i, in_valid_i,    operand limb stream (valid/ready)
//   in_ready_o
//   add_a_o, add_b_o,        registered operands to the adder
//   add_cin_o, add_sum_i     and its combinational {carry_out, sum} result
//   out_sum_o, out_last_o,   result limb stream (valid/ready)
//   out_valid_o, out_ready_i
//   cout_o, busy_o, done_o   final carry, activity flag, end-of-operation pulse

module bk_limb_sequencer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [3:0]   len_i,
  input  logic         cin_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] add_a_o,
  output logic [W-1:0] add_b_o,
  output logic         add_cin_o,
  input  logic [W:0]   add_sum_i,
  output logic [W-1:0] out_sum_o,
  output logic         out_last_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         cout_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ADD  = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       carry_q;
  logic [3:0] remaining_q;

  logic       in_fire;
  logic       out_fire;

  // in_ready_o / out_valid_o are flops that mirror LOAD / EMIT, so using them
  // in the handshake terms is equivalent to a state compare and input-free.
  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_i && (len_i != 4'd0)) state_nxt = S_LOAD;
      S_LOAD: if (in_fire) state_nxt = S_ADD;
      S_ADD:  state_nxt = S_EMIT;
      S_EMIT: if (out_fire) state_nxt = out_last_o ? S_DONE : S_LOAD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control flops: the status outputs are decoded from the next state and
  // registered so they track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_o  <= (state_nxt == S_LOAD);
      out_valid_o <= (state_nxt == S_EMIT);
      busy_o      <= (state_nxt != S_IDLE);
      done_o      <= (state_nxt == S_DONE);
    end
  end

  // Datapath flops: each register only moves in the one state that owns it,
  // which is what keeps everything frozen while EMIT is back-pressured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q     <= 1'b0;
      remaining_q <= 4'd0;
      add_a_o     <= '0;
      add_b_o     <= '0;
      add_cin_o   <= 1'b0;
      out_sum_o   <= '0;
      out_last_o  <= 1'b0;
      cout_o      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && (len_i != 4'd0)) begin
            carry_q     <= cin_i;
            remaining_q <= len_i;
            cout_o      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_fire) begin
            add_a_o     <= a_i;
            add_b_o     <= b_i;
            add_cin_o   <= carry_q;
            remaining_q <= remaining_q - 4'd1;
          end
        end
        S_ADD: begin
          // Adder inputs have been stable for a full cycle; capture its result.
          out_sum_o  <= add_sum_i[W-1:0];
          carry_q    <= add_sum_i[W];
          out_last_o <= (remaining_q == 4'd0);
        end
        S_EMIT: begin
          if (out_fire && out_last_o) begin
            cout_o <= carry_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bk_limb_sequencer.sv
module tb_bk_limb_sequencer;

  localparam int W = 6;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic [3:0]   len_i;
  logic         cin_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] add_a_o;
  logic [W-1:0] add_b_o;
  logic         add_cin_o;
  logic [W:0]   add_sum_i;
  logic [W-1:0] out_sum_o;
  logic         out_last_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         cout_o;
  logic         busy_o;
  logic         done_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic last_cout = 1'b0;

  bk_limb_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .cin_i(cin_i),
    .a_i(a_i), .b_i(b_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_cin_o(add_cin_o),
    .add_sum_i(add_sum_i), .out_sum_o(out_sum_o), .out_last_o(out_last_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .cout_o(cout_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // The external carry-in adder.
  assign add_sum_i = {1'b0, add_a_o} + {1'b0, add_b_o} + {{W{1'b0}}, add_cin_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".in_ready"},  64'(in_ready_o),  0);
    check({tag, ".out_valid"}, 64'(out_valid_o), 0);
    check({tag, ".out_last"},  64'(out_last_o),  0);
    check({tag, ".out_sum"},   64'(out_sum_o),   0);
    check({tag, ".add_a"},     64'(add_a_o),     0);
    check({tag, ".add_b"},     64'(add_b_o),     0);
    check({tag, ".add_cin"},   64'(add_cin_o),   0);
    check({tag, ".cout"},      64'(cout_o),      0);
    check({tag, ".busy"},      64'(busy_o),      0);
    check({tag, ".done"},      64'(done_o),      0);
  endtask

  task automatic noise(input bit en);
    if (en) begin
      start_i    = 1'($urandom);
      len_i      = 4'($urandom);
      cin_i      = 1'($urandom);
      in_valid_i = 1'($urandom);
      a_i        = W'($urandom);
      b_i        = W'($urandom);
    end
  endtask

  // Full operation: the reference result is the whole-width sum A+B+cin.
  // stall < 0 picks a random per-limb backpressure of 0..3 cycles.
  task automatic run_op(input int len, input bit cin, input logic [89:0] a_all,
                        input logic [89:0] b_all, input int stall, input bit nz);
    logic [90:0] mask, tot, pmask, part;
    logic [W-1:0] la, lb, el;
    logic ci;
    int st, gap;
    mask = (91'd1 << (W * len)) - 91'd1;
    tot  = ({1'b0, a_all} & mask) + ({1'b0, b_all} & mask) + 91'(cin);
    tick;
    start_i = 1'b1; len_i = 4'(len); cin_i = cin; in_valid_i = 1'b0; out_ready_i = 1'b0;
    tick;
    start_i = 1'b0;
    noise(nz);
    for (int i = 0; i < len; i++) begin
      la = a_all[W*i +: W];
      lb = b_all[W*i +: W];
      el = tot[W*i +: W];
      pmask = (91'd1 << (W * i)) - 91'd1;
      part  = ({1'b0, a_all} & pmask) + ({1'b0, b_all} & pmask) + 91'(cin);
      ci = part[W*i];
      a_i = la; b_i = lb; in_valid_i = 1'b0;
      gap = $urandom_range(2, 0);
      repeat (gap) begin
        @(negedge clk);
        check("load.in_ready", 64'(in_ready_o), 1);
        check("load.busy", 64'(busy_o), 1);
        tick;
      end
      in_valid_i = 1'b1;
      @(negedge clk);
      check("load.in_ready", 64'(in_ready_o), 1);
      check("load.out_valid", 64'(out_valid_o), 0);
      tick;
      in_valid_i = 1'b0;
      noise(nz);
      @(negedge clk);
      check("add.out_valid", 64'(out_valid_o), 0);
      check("add.in_ready", 64'(in_ready_o), 0);
      check("add.a", 64'(add_a_o), 64'(la));
      check("add.b", 64'(add_b_o), 64'(lb));
      check("add.cin", 64'(add_cin_o), 64'(ci));
      tick;
      noise(nz);
      @(negedge clk);
      check("emit.out_valid", 64'(out_valid_o), 1);
      check("emit.sum", 64'(out_sum_o), 64'(el));
      check("emit.last", 64'(out_last_o), 64'(i == len - 1));
      st = (stall < 0) ? $urandom_range(3, 0) : stall;
      repeat (st) begin
        tick;
        noise(nz);
        @(negedge clk);
        check("hold.out_valid", 64'(out_valid_o), 1);
        check("hold.sum", 64'(out_sum_o), 64'(el));
        check("hold.last", 64'(out_last_o), 64'(i == len - 1));
        check("hold.add_a", 64'(add_a_o), 64'(la));
        check("hold.done", 64'(done_o), 0);
      end
      out_ready_i = 1'b1;
      tick;
      out_ready_i = 1'b0;
      if (i == len - 1) begin
        start_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        check("done.pulse", 64'(done_o), 1);
        check("done.busy", 64'(busy_o), 1);
        check("done.out_valid", 64'(out_valid_o), 0);
        check("done.cout", 64'(cout_o), 64'(tot[W*len]));
        tick;
        @(negedge clk);
        check("idle.done", 64'(done_o), 0);
        check("idle.busy", 64'(busy_o), 0);
        check("idle.cout", 64'(cout_o), 64'(tot[W*len]));
        last_cout = tot[W*len];
      end else begin
        noise(nz);
        start_i = 1'($urandom);
      end
    end
  endtask

  initial begin
    logic [89:0] ra, rb;
    rst = 1'b0; start_i = 1'b0; len_i = '0; cin_i = 1'b0; a_i = '0; b_i = '0;
    in_valid_i = 1'b0; out_ready_i = 1'b0;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #3 rst = 1'b1;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases.
    run_op(1, 1'b0, 90'd63, 90'd1, 0, 1'b0);
    run_op(2, 1'b0, 90'((5 << 6) | 63), 90'((2 << 6) | 1), 0, 1'b0);
    run_op(1, 1'b1, 90'd0, 90'd0, 5, 1'b0);
    run_op(15, 1'b1, {90{1'b1}}, 90'd0, 0, 1'b0);

    // len_i = 0 is ignored.
    tick;
    start_i = 1'b1; len_i = 4'd0; cin_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("len0.busy", 64'(busy_o), 0);
      check("len0.in_ready", 64'(in_ready_o), 0);
      check("len0.cout", 64'(cout_o), 64'(last_cout));
      tick;
    end

    // Abort during the ADD of limb 1 of a 3-limb operation.
    tick;
    start_i = 1'b1; len_i = 4'd3; cin_i = 1'b0;
    tick;
    start_i = 1'b0;
    a_i = 6'd1; b_i = 6'd2; in_valid_i = 1'b1;
    tick;
    in_valid_i = 1'b0;
    tick;
    out_ready_i = 1'b1;
    tick;
    out_ready_i = 1'b0;
    a_i = 6'd5; b_i = 6'd7; in_valid_i = 1'b1;
    tick;
    in_valid_i = 1'b0;
    @(negedge clk);
    check("abort.pre_busy", 64'(busy_o), 1);
    check("abort.pre_add_a", 64'(add_a_o), 5);
    #2 rst = 1'b1;
    #1 check_zero("abort");
    out_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort.out_valid", 64'(out_valid_o), 0);
      check("abort.done", 64'(done_o), 0);
    end
    tick;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_abort.out_valid", 64'(out_valid_o), 0);
      check("post_abort.busy", 64'(busy_o), 0);
      tick;
    end
    out_ready_i = 1'b0;
    run_op(1, 1'b0, 90'd10, 90'd20, 0, 1'b0);

    // Randomised operations with stray inputs outside their states.
    for (int k = 0; k < 30; k++) begin
      ra = {$urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom};
      run_op($urandom_range(15, 1), 1'($urandom), ra, rb, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
